// File: rtl/gauss3x3_rgb888_filter.sv
// ---------------------------------------------------------------------------
// gauss3x3_rgb888_filter
//
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16, rounded) on RGB888 pixels.
// Each 8-bit channel is filtered on its own. The result is written
// sequentially into a framebuffer. Pipeline stages:
//   S1 : weighted row sums, 10 bits per channel
//   S2 : weighted total, 12 bits per channel
//   S3 : rounded result, registered onto oData, with the write strobe
// A bypass flag travels with each window. When it is set, the centre pixel
// is written unfiltered.
//
// Ports
//   iClk        clock; all state changes on its rising edge
//   iRst        asynchronous active-high reset
//   iEn         global advance enable (0 = full stall, no writes)
//   iValid      iIn0..iIn8 hold a valid window this cycle
//   iIn0..iIn8  3x3 window in row-major order, iIn4 is the centre
//   iBypass     pass the centre pixel unfiltered
//   oWe         framebuffer write strobe
//   oAddr       framebuffer write address (0 .. DEPTH-1, then wraps)
//   oData       filtered pixel
//   oFrameDone  one-cycle pulse together with the write of DEPTH-1
//   oBusy       high while the frame FSM is in RUN
// ---------------------------------------------------------------------------
module gauss3x3_rgb888_filter #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 130560
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iIn0,
  input  logic [DATA_W-1:0] iIn1,
  input  logic [DATA_W-1:0] iIn2,
  input  logic [DATA_W-1:0] iIn3,
  input  logic [DATA_W-1:0] iIn4,
  input  logic [DATA_W-1:0] iIn5,
  input  logic [DATA_W-1:0] iIn6,
  input  logic [DATA_W-1:0] iIn7,
  input  logic [DATA_W-1:0] iIn8,
  input  logic              iBypass,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic              oFrameDone,
  output logic              oBusy
);

  localparam int NCH = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // a + 2b + c. The maximum is 4 * 255 = 1020, which fits 10 bits.
  function automatic logic [9:0] row_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    return 10'(a) + (10'(b) << 1) + 10'(c);
  endfunction

  // Pipeline state
  logic                    valid_s1, valid_s2, valid_s3;
  logic                    byp_s1, byp_s2;
  logic [DATA_W-1:0]       ctr_s1, ctr_s2;
  logic [NCH-1:0][9:0]     row0_s1, row1_s1, row2_s1;
  logic [NCH-1:0][11:0]    sum_s2;
  logic [DATA_W-1:0]       filt;
  logic                    last_addr;
  state_t                  state;

  // S1..S3 data path. Everything freezes while iEn is low.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      // NOTE: the data registers are cleared as well as the valid bits,
      // because oData has to read 0 during reset and right after it.
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      valid_s3 <= 1'b0;
      byp_s1   <= 1'b0;
      byp_s2   <= 1'b0;
      ctr_s1   <= '0;
      ctr_s2   <= '0;
      row0_s1  <= '0;
      row1_s1  <= '0;
      row2_s1  <= '0;
      sum_s2   <= '0;
      oData    <= '0;
    end else if (iEn) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge, which is what forms the pipeline.
      valid_s1 <= iValid;
      valid_s2 <= valid_s1;
      valid_s3 <= valid_s2;
      byp_s1   <= iBypass;
      byp_s2   <= byp_s1;
      ctr_s1   <= iIn4;
      ctr_s2   <= ctr_s1;
      for (int ch = 0; ch < NCH; ch++) begin
        row0_s1[ch] <= row_sum(iIn0[8*ch +: 8], iIn1[8*ch +: 8], iIn2[8*ch +: 8]);
        row1_s1[ch] <= row_sum(iIn3[8*ch +: 8], iIn4[8*ch +: 8], iIn5[8*ch +: 8]);
        row2_s1[ch] <= row_sum(iIn6[8*ch +: 8], iIn7[8*ch +: 8], iIn8[8*ch +: 8]);
        // The middle row carries twice the weight of the outer rows.
        sum_s2[ch]  <= 12'(row0_s1[ch]) + (12'(row1_s1[ch]) << 1) + 12'(row2_s1[ch]);
      end
      oData <= byp_s2 ? ctr_s2 : filt;
    end
  end

  // Round to nearest: (sum + 8) >> 4. The maximum is 4088 >> 4 = 255, so no
  // clamp is needed.
  always_comb begin
    // NOTE: a default is assigned first on every path, so no latch is inferred.
    filt = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      logic [11:0] rnd;
      rnd = sum_s2[ch] + 12'd8;
      filt[8*ch +: 8] = rnd[11:4];
    end
  end

  assign oWe        = valid_s3 & iEn;
  assign last_addr  = (oAddr == LAST_ADDR);
  assign oFrameDone = oWe & last_addr;
  assign oBusy      = (state == RUN);

  // Address counter and frame FSM. The FSM only reports status and never
  // gates the pipeline. A newly accepted window takes priority over the
  // end-of-frame transition, so back-to-back frames stay in RUN.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oAddr <= '0;
      state <= IDLE;
    end else if (iEn) begin
      if (valid_s3) oAddr <= last_addr ? '0 : oAddr + ADDR_W'(1);
      if (iValid)                     state <= RUN;
      else if (valid_s3 && last_addr) state <= IDLE;
    end
  end

endmodule

// File: doc/gauss3x3_rgb888_filter.md
GAUSS3X3_RGB888_FILTER -- requirements
Module: gauss3x3_rgb888_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning pixel width (RGB888: R=[23:16], G=[15:8], B=[7:0]).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning output framebuffer address width.
REQ-003 SHALL have parameter DEPTH, default 130560, meaning pixels per frame (480x272).
REQ-004 SHALL have port iClk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port iRst, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have port iEn, input, 1, global advance enable; 0 = full stall.
REQ-007 SHALL have port iValid, input, 1, indicating that iIn0..iIn8 hold a valid 3x3 window this cycle.
REQ-008 SHALL have ports iIn0..iIn8, input, DATA_W each, window in row-major order with iIn4 as the centre.
REQ-009 SHALL have port iBypass, input, 1; 1 = pass the centre pixel unfiltered.
REQ-010 SHALL have port oWe, input-side name oWe, output, 1, framebuffer write strobe.
REQ-011 SHALL have port oAddr, output, ADDR_W, framebuffer write address.
REQ-012 SHALL have port oData, output, DATA_W, filtered pixel.
REQ-013 SHALL have port oFrameDone, output, 1, one-cycle pulse on the last write of a frame.
REQ-014 SHALL have port oBusy, output, 1, high while the FSM is in RUN.

Function
REQ-015 SHALL apply kernel [1 2 1; 2 4 2; 1 2 1] independently per 8-bit channel.
REQ-016 SHALL compute per-channel result = (sum + 8) >> 4, with sum carried in 12 bits; the result never exceeds 255, so no saturation logic.
REQ-017 SHALL pipeline in 3 register stages:
- S1: per-row weighted sums, 10 bits.
- S2: 12-bit total.
- S3: rounded result plus write.
REQ-018 SHALL give oWe a latency of exactly 3 enabled cycles after the accepted iValid.
REQ-019 SHALL carry iBypass alongside the data through the pipeline; when set, oData = iIn4 sampled with the same window.
REQ-020 SHALL accept a window only when iEn=1 and iValid=1; windows with iValid=0 produce no write.
REQ-021 SHALL hold all pipeline data, valid bits, counter and FSM when iEn=0, and force oWe=0 during the stall.
REQ-022 SHALL drive oWe = S3 valid AND iEn, with oData and oAddr stable while oWe=1.
REQ-023 SHALL have oAddr start at 0 and increment by 1 after each oWe cycle.
REQ-024 SHALL write address DEPTH-1 with oFrameDone=1 in the same cycle, after which oAddr wraps to 0.
REQ-025 SHALL implement FSM states IDLE and RUN:
- IDLE -> RUN on an accepted iValid.
- RUN -> IDLE on the write of DEPTH-1.
- If the last write and an accepted iValid coincide, the next state is RUN.
REQ-026 SHALL not gate pipeline flow on FSM state; windows accepted in IDLE are processed normally.
REQ-027 SHALL assert oBusy = (state == RUN).

Reset
REQ-028 SHALL, on iRst=1 and asynchronously, clear all pipeline registers, valid bits, address counter and FSM (IDLE).
REQ-029 SHALL hold oWe=0, oAddr=0, oData=0, oFrameDone=0 and oBusy=0 throughout reset.
REQ-030 SHALL discard in-flight windows on reset mid-frame; the first write after release goes to oAddr=0.

Verification
REQ-031 SHALL be verified by this scenario: all nine inputs 0x808080, iValid=1 for one cycle, iEn=1 -> oWe=1 exactly 3 cycles later with oData=0x808080, oAddr=0.
REQ-032 SHALL be verified by this scenario: iIn4=0xFFFFFF, others 0 -> oData=0x404040; all inputs 0xFFFFFF -> oData=0xFFFFFF; iIn0=0x0000FF, others 0 -> oData=0x000010.
REQ-033 SHALL be verified by this scenario: iBypass=1, iIn4=0x123456, others 0xFFFFFF -> oData=0x123456.
REQ-034 SHALL be verified by this scenario: 3 back-to-back windows with iEn dropped for 2 cycles after the first -> exactly 3 writes at oAddr 0,1,2, none during the stall, data in order.
REQ-035 SHALL be verified by this scenario: DEPTH=4 and 5 windows -> writes at 0,1,2,3,0; oFrameDone high only on the addr-3 write; oBusy low for exactly 1 cycle after it (no coincident iValid).
REQ-036 SHALL be verified by this scenario: iRst pulsed while 2 windows are in flight at oAddr=7 -> no writes, outputs 0; the next window writes at oAddr=0.
